password_attempt_controller: RTL

//  Sequences a keypad-style code entry for the password lock: collects NUM_DIGITS BCD digits,

---
 rtl/password_pkg.sv | 22 ++
 rtl/password_attempt_controller_if.sv | 32 +++
 rtl/password_tick_timer.sv | 29 ++
 rtl/password_attempt_controller.sv | 174 +++++++++++++++++
 4 files changed

// File: rtl/password_pkg.sv
// Shared types and widths for the password lock code-entry controller.
package password_pkg;

  localparam int unsigned DIGIT_W = 4;
  localparam int unsigned BCD_MAX = 9;
  localparam int unsigned TIMER_W = 8;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_ENTRY    = 3'd1,
    ST_CHECK    = 3'd2,
    ST_UNLOCKED = 3'd3,
    ST_FAIL     = 3'd4,
    ST_LOCKOUT  = 3'd5,
    ST_PROGRAM  = 3'd6
  } state_t;

  function automatic logic is_bcd(input logic [DIGIT_W-1:0] d);
    return d <= DIGIT_W'(BCD_MAX);
  endfunction

endpackage

// File: rtl/password_attempt_controller_if.sv
// Keypad-decoder / display-side signal bundle for the password attempt controller.
interface password_attempt_controller_if;
  import password_pkg::*;

  logic               tick;
  logic               digit_valid;
  logic [DIGIT_W-1:0] digit_val;
  logic               clear;
  logic               lock_req;
  logic               prog_req;
  logic               unlocked;
  logic               locked_out;
  logic               fail_pulse;
  logic               prog_done;
  logic [3:0]         attempts_left;
  logic [3:0]         digit_count;
  logic [TIMER_W-1:0] time_left;
  logic [2:0]         state_out;

  modport master (
    output tick, digit_valid, digit_val, clear, lock_req, prog_req,
    input  unlocked, locked_out, fail_pulse, prog_done,
           attempts_left, digit_count, time_left, state_out
  );

  modport slave (
    input  tick, digit_valid, digit_val, clear, lock_req, prog_req,
    output unlocked, locked_out, fail_pulse, prog_done,
           attempts_left, digit_count, time_left, state_out
  );

endinterface

// File: rtl/password_tick_timer.sv
// Loadable down-counter advanced by tick pulses; expire flags the tick that reaches zero.
module password_tick_timer
  import password_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               tick,
  input  logic               load,
  input  logic               clr,
  input  logic [TIMER_W-1:0] load_val,
  output logic [TIMER_W-1:0] count,
  output logic               expire
);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (tick && (count != '0)) begin
      count <= count - TIMER_W'(1);
    end
  end

  assign expire = tick && (count == TIMER_W'(1));

endmodule

// File: rtl/password_attempt_controller.sv
// Code-entry sequencer: collects BCD digits, compares with the stored code, counts failures,
// enforces a timed lockout and allows re-programming the code while unlocked.
module password_attempt_controller
  import password_pkg::*;
#(
  parameter int unsigned                      NUM_DIGITS    = 4,
  parameter int unsigned                      MAX_ATTEMPTS  = 3,
  parameter int unsigned                      LOCKOUT_TICKS = 30,
  parameter int unsigned                      UNLOCK_TICKS  = 10,
  parameter logic [NUM_DIGITS*DIGIT_W-1:0]    DEFAULT_CODE  = 16'h2016
)
(
  input  logic                          clk,
  input  logic                          rst,
  password_attempt_controller_if.slave  bus
);

  localparam int unsigned BUF_W = NUM_DIGITS * DIGIT_W;

  state_t             state_q, state_d;
  logic [BUF_W-1:0]   buf_q, buf_d;
  logic [BUF_W-1:0]   code_q, code_d;
  logic [3:0]         att_q, att_d;
  logic [3:0]         cnt_q, cnt_d;
  logic               prog_done_q, prog_done_d;

  logic               tmr_tick, tmr_load, tmr_clr, tmr_expire;
  logic [TIMER_W-1:0] tmr_val, tmr_count;

  logic               dig_ok;
  logic               last_digit;
  logic [BUF_W-1:0]   buf_shift;

  assign dig_ok     = bus.digit_valid && is_bcd(bus.digit_val);
  assign last_digit = (cnt_q == 4'(NUM_DIGITS - 1));
  assign buf_shift  = (buf_q << DIGIT_W) | BUF_W'(bus.digit_val);
  assign tmr_tick   = bus.tick && ((state_q == ST_LOCKOUT) || (state_q == ST_UNLOCKED));

  password_tick_timer u_timer (
    .clk      (clk),
    .rst      (rst),
    .tick     (tmr_tick),
    .load     (tmr_load),
    .clr      (tmr_clr),
    .load_val (tmr_val),
    .count    (tmr_count),
    .expire   (tmr_expire)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      buf_q       <= '0;
      code_q      <= DEFAULT_CODE;
      att_q       <= 4'(MAX_ATTEMPTS);
      cnt_q       <= '0;
      prog_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      buf_q       <= buf_d;
      code_q      <= code_d;
      att_q       <= att_d;
      cnt_q       <= cnt_d;
      prog_done_q <= prog_done_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    buf_d       = buf_q;
    code_d      = code_q;
    att_d       = att_q;
    cnt_d       = cnt_q;
    prog_done_d = 1'b0;
    tmr_load    = 1'b0;
    tmr_clr     = 1'b0;
    tmr_val     = TIMER_W'(UNLOCK_TICKS);

    unique case (state_q)
      ST_IDLE: begin
        if (dig_ok) begin
          buf_d   = buf_shift;
          cnt_d   = cnt_q + 4'd1;
          state_d = last_digit ? ST_CHECK : ST_ENTRY;
        end
      end
      ST_ENTRY: begin
        if (bus.clear) begin
          buf_d   = '0;
          cnt_d   = '0;
          state_d = ST_IDLE;
        end else if (dig_ok) begin
          buf_d   = buf_shift;
          cnt_d   = cnt_q + 4'd1;
          state_d = last_digit ? ST_CHECK : ST_ENTRY;
        end
      end
      ST_CHECK: begin
        cnt_d = '0;
        if (buf_q == code_q) begin
          att_d    = 4'(MAX_ATTEMPTS);
          tmr_load = 1'b1;
          tmr_val  = TIMER_W'(UNLOCK_TICKS);
          state_d  = ST_UNLOCKED;
        end else begin
          state_d  = ST_FAIL;
        end
      end
      ST_FAIL: begin
        att_d = att_q - 4'd1;
        if (att_q == 4'd1) begin
          tmr_load = 1'b1;
          tmr_val  = TIMER_W'(LOCKOUT_TICKS);
          state_d  = ST_LOCKOUT;
        end else begin
          state_d  = ST_IDLE;
        end
      end
      ST_LOCKOUT: begin
        if (tmr_expire) begin
          att_d   = 4'(MAX_ATTEMPTS);
          state_d = ST_IDLE;
        end
      end
      ST_UNLOCKED: begin
        // The timer only runs in LOCKOUT/UNLOCKED, so it is cleared on every exit to keep time_left at 0.
        if (bus.lock_req) begin
          tmr_clr = 1'b1;
          state_d = ST_IDLE;
        end else if (bus.prog_req) begin
          tmr_clr = 1'b1;
          buf_d   = '0;
          cnt_d   = '0;
          state_d = ST_PROGRAM;
        end else if (tmr_expire) begin
          state_d = ST_IDLE;
        end
      end
      ST_PROGRAM: begin
        if (bus.clear) begin
          buf_d    = '0;
          cnt_d    = '0;
          tmr_load = 1'b1;
          tmr_val  = TIMER_W'(UNLOCK_TICKS);
          state_d  = ST_UNLOCKED;
        end else if (dig_ok) begin
          if (last_digit) begin
            code_d      = buf_shift;
            prog_done_d = 1'b1;
            buf_d       = '0;
            cnt_d       = '0;
            state_d     = ST_IDLE;
          end else begin
            buf_d = buf_shift;
            cnt_d = cnt_q + 4'd1;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign bus.unlocked      = (state_q == ST_UNLOCKED);
  assign bus.locked_out    = (state_q == ST_LOCKOUT);
  assign bus.fail_pulse    = (state_q == ST_FAIL);
  assign bus.prog_done     = prog_done_q;
  assign bus.attempts_left = att_q;
  assign bus.digit_count   = cnt_q;
  assign bus.time_left     = tmr_count;
  assign bus.state_out     = state_q;

endmodule
